stc_aloader: RTL and testbench

//   Producer side of the stc_Abuffer write interface. Accepts one dense A row per handshake and compacts its nonzeros.

---
 rtl/stc_aloader.sv | 242 ++++++++++++++++++++++++
 tb/tb_stc_aloader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stc_aloader.sv
// -----------------------------------------------------------------------------
// stc_aloader
// Producer side of the stc_Abuffer write interface. Takes one dense A row per
// valid/ready handshake, scans it LANES columns per cycle in ascending column
// order, and packs the nonzero values and their column indices into the
// low-order slots of two buses. The packed row is then written into
// stc_Abuffer with two one-cycle strobes: data first, then column indices.
// The column-index strobe also carries the row's nonzero count and the running
// nonzero pointer of the tile.
//
// Ports
//   clk            clock
//   reset          asynchronous, active-high reset
//   in_valid       dense row present on in_row
//   in_ready       loader can accept a row (high only when idle)
//   in_row         dense row, element j at [j*DW_DATA +: DW_DATA]
//   in_last        accepted row is the last row of the tile
//   write_data_en  one-cycle strobe: A_data_input valid for row idx
//   write_cidx_en  one-cycle strobe: A_colidx_input valid for row idx
//   A_data_input   packed nonzeros, slot s at [s*DW_DATA +: DW_DATA]
//   A_colidx_input packed column indices, slot s at [s*DW_COL +: DW_COL]
//   idx            target row in stc_Abuffer
//   row_nnz        nonzero count of the row (valid with write_cidx_en)
//   row_ptr        cumulative nnz of earlier rows in the tile (valid with write_cidx_en)
//   tile_done      one-cycle pulse with write_cidx_en of the tile's final row
// -----------------------------------------------------------------------------
module stc_aloader #(
    parameter int M       = 16,
    parameter int K       = 16,
    parameter int DW_MEM  = 256,
    parameter int DW_DATA = 16,
    parameter int DW_COL  = 4,
    parameter int DW_PTR  = 8,
    parameter int LANES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW_MEM-1:0]     in_row,
    input  logic                  in_last,
    output logic                  write_data_en,
    output logic                  write_cidx_en,
    output logic [DW_MEM-1:0]     A_data_input,
    output logic [DW_MEM-1:0]     A_colidx_input,
    output logic [DW_COL-1:0]     idx,
    output logic [$clog2(K):0]    row_nnz,
    output logic [DW_PTR-1:0]     row_ptr,
    output logic                  tile_done
);

    localparam int NW = $clog2(K) + 1;
    localparam int AW = $clog2(DW_MEM);
    // Column base of the final scan group; reaching it ends SCAN.
    localparam logic [DW_COL-1:0] LAST_COL_BASE = DW_COL'(K - LANES);
    localparam logic [DW_COL-1:0] LAST_ROW      = DW_COL'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SCAN    = 2'd1,
        S_WR_DATA = 2'd2,
        S_WR_CIDX = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Working copy of the row; shifted down by one lane group per scan cycle
    // so the lanes under inspection always sit at the bottom.
    logic [DW_MEM-1:0]   r_row;
    logic                r_last;
    logic [DW_COL-1:0]   r_col;
    logic [NW-1:0]       r_nnz;
    logic [DW_MEM-1:0]   r_pack_data;
    logic [DW_MEM-1:0]   r_pack_cidx;

    // Output-side registers; held from WR_DATA until the next WR_DATA.
    logic [DW_MEM-1:0]   r_a_data;
    logic [DW_MEM-1:0]   r_a_cidx;
    logic [DW_COL-1:0]   r_idx;
    logic [NW-1:0]       r_row_nnz;
    logic [DW_PTR-1:0]   r_row_ptr;
    logic                r_in_ready;
    logic                r_wr_data_en;
    logic                r_wr_cidx_en;
    logic                r_tile_done;

    // Tile-level bookkeeping: next target row and running nnz pointer.
    logic [DW_COL-1:0]   r_idx_cnt;
    logic [DW_PTR-1:0]   r_ptr_acc;

    logic [DW_MEM-1:0]   w_pack_data_nxt;
    logic [DW_MEM-1:0]   w_pack_cidx_nxt;
    logic [NW-1:0]       w_nnz_nxt;
    logic [DW_DATA-1:0]  w_elem;
    logic [AW-1:0]       w_dbase;
    logic [AW-1:0]       w_cbase;
    logic                w_scan_done;
    logic                w_tile_end;

    assign w_scan_done = (r_col == LAST_COL_BASE);
    // Tile ends on an explicit last row or when the buffer's last row is written.
    assign w_tile_end  = r_last || (r_idx_cnt == LAST_ROW);

    // Compaction of one lane group: each nonzero lane is appended at the
    // current fill level, so lower columns always land in lower slots.
    always_comb begin
        w_pack_data_nxt = r_pack_data;
        w_pack_cidx_nxt = r_pack_cidx;
        w_nnz_nxt       = r_nnz;
        w_elem          = '0;
        w_dbase         = '0;
        w_cbase         = '0;
        for (int l = 0; l < LANES; l++) begin
            w_elem  = r_row[l*DW_DATA +: DW_DATA];
            w_dbase = AW'(w_nnz_nxt) * AW'(DW_DATA);
            w_cbase = AW'(w_nnz_nxt) * AW'(DW_COL);
            if (w_elem != '0) begin
                w_pack_data_nxt[w_dbase +: DW_DATA] = w_elem;
                w_pack_cidx_nxt[w_cbase +: DW_COL]  = r_col + DW_COL'(l);
                w_nnz_nxt                           = w_nnz_nxt + NW'(1);
            end else begin
                w_nnz_nxt = w_nnz_nxt;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_state_nxt = S_SCAN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                if (w_scan_done) begin
                    w_state_nxt = S_WR_DATA;
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_WR_DATA: w_state_nxt = S_WR_CIDX;
            S_WR_CIDX: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, registered handshake/strobe outputs and tile bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row        <= '0;
            r_last       <= 1'b0;
            r_col        <= '0;
            r_nnz        <= '0;
            r_pack_data  <= '0;
            r_pack_cidx  <= '0;
            r_a_data     <= '0;
            r_a_cidx     <= '0;
            r_idx        <= '0;
            r_row_nnz    <= '0;
            r_row_ptr    <= '0;
            r_in_ready   <= 1'b1;
            r_wr_data_en <= 1'b0;
            r_wr_cidx_en <= 1'b0;
            r_tile_done  <= 1'b0;
            r_idx_cnt    <= '0;
            r_ptr_acc    <= '0;
        end else begin
            // Strobes and ready are decoded from the next state so they are
            // flop outputs aligned with the state they describe.
            r_in_ready   <= (w_state_nxt == S_IDLE);
            r_wr_data_en <= (w_state_nxt == S_WR_DATA);
            r_wr_cidx_en <= (w_state_nxt == S_WR_CIDX);
            r_tile_done  <= (r_state == S_WR_DATA) && w_tile_end;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_row       <= in_row;
                        r_last      <= in_last;
                        r_col       <= '0;
                        r_nnz       <= '0;
                        r_pack_data <= '0;
                        r_pack_cidx <= '0;
                    end
                end
                S_SCAN: begin
                    r_row       <= r_row >> (LANES * DW_DATA);
                    r_col       <= r_col + DW_COL'(LANES);
                    r_nnz       <= w_nnz_nxt;
                    r_pack_data <= w_pack_data_nxt;
                    r_pack_cidx <= w_pack_cidx_nxt;
                    // Final group: publish the finished row on the output buses.
                    if (w_scan_done) begin
                        r_a_data <= w_pack_data_nxt;
                        r_a_cidx <= w_pack_cidx_nxt;
                        r_idx    <= r_idx_cnt;
                    end
                end
                S_WR_DATA: begin
                    r_row_nnz <= r_nnz;
                    r_row_ptr <= r_ptr_acc;
                end
                S_WR_CIDX: begin
                    if (w_tile_end) begin
                        r_idx_cnt <= '0;
                        r_ptr_acc <= '0;
                    end else begin
                        r_idx_cnt <= r_idx_cnt + DW_COL'(1);
                        r_ptr_acc <= r_ptr_acc + DW_PTR'(r_row_nnz);
                    end
                end
                default: begin
                    r_idx_cnt <= r_idx_cnt;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign write_data_en  = r_wr_data_en;
    assign write_cidx_en  = r_wr_cidx_en;
    assign A_data_input   = r_a_data;
    assign A_colidx_input = r_a_cidx;
    assign idx            = r_idx;
    assign row_nnz        = r_row_nnz;
    assign row_ptr        = r_row_ptr;
    assign tile_done      = r_tile_done;

endmodule

// File: tb/tb_stc_aloader.sv
// -----------------------------------------------------------------------------
// tb_stc_aloader
// Scoreboard bench for stc_aloader. Every accepted row is compacted by a small
// reference model and pushed to a queue together with its expected idx,
// row_ptr and tile_done; a negedge monitor compares the DUT write strobes
// against the head of the queue and checks strobe timing after each handshake.
// -----------------------------------------------------------------------------
module tb_stc_aloader;

    typedef struct {
        logic [255:0] data;
        logic [255:0] cidx;
        logic [4:0]   nnz;
        logic [3:0]   idx;
        logic [7:0]   ptr;
        logic         td;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_row;
    logic         in_last;
    logic         write_data_en;
    logic         write_cidx_en;
    logic [255:0] A_data_input;
    logic [255:0] A_colidx_input;
    logic [3:0]   idx;
    logic [4:0]   row_nnz;
    logic [7:0]   row_ptr;
    logic         tile_done;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           cyc      = 0;
    int           hs_cyc   = 0;
    bit           tmon_en  = 1'b0;
    logic [3:0]   m_idx    = 4'd0;
    logic [7:0]   m_ptr    = 8'd0;
    logic [255:0] row_v;

    stc_aloader dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_row         (in_row),
        .in_last        (in_last),
        .write_data_en  (write_data_en),
        .write_cidx_en  (write_cidx_en),
        .A_data_input   (A_data_input),
        .A_colidx_input (A_colidx_input),
        .idx            (idx),
        .row_nnz        (row_nnz),
        .row_ptr        (row_ptr),
        .tile_done      (tile_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: compact the row and track idx / row_ptr across the tile.
    task automatic push_expected(input logic [255:0] row, input logic last);
        exp_t        e;
        int          n;
        logic [15:0] v;
        n      = 0;
        e.data = '0;
        e.cidx = '0;
        for (int j = 0; j < 16; j++) begin
            v = row[j*16 +: 16];
            if (v != 16'h0000) begin
                e.data[n*16 +: 16] = v;
                e.cidx[n*4 +: 4]   = 4'(j);
                n++;
            end
        end
        e.nnz = 5'(n);
        e.idx = m_idx;
        e.ptr = m_ptr;
        e.td  = last || (m_idx == 4'd15);
        if (e.td) begin
            m_idx = 4'd0;
            m_ptr = 8'd0;
        end else begin
            m_idx = m_idx + 4'd1;
            m_ptr = m_ptr + 8'(n);
        end
        sb.push_back(e);
    endtask

    // Called #1 after a posedge; offers a row and keeps in_valid up for 'hold' cycles.
    task automatic send_row(input logic [255:0] row, input logic last, input int hold);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check_val("ready_wait", in_ready, 1'b1);
        push_expected(row, last);
        in_valid = 1'b1;
        in_row   = row;
        in_last  = last;
        hs_cyc   = cyc;
        tmon_en  = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_row   = {8{$urandom()}};
    endtask

    // Scoreboard monitor: compare strobes against the queue head, check timing.
    always @(negedge clk) begin
        if (!reset) begin
            check_val("strobe_excl", write_data_en & write_cidx_en, 1'b0);
            if (!write_cidx_en) begin
                check_val("td_idle", tile_done, 1'b0);
            end
            if (write_data_en) begin
                check_val("sb_nonempty_wd", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    check_val("wd_data", A_data_input, sb[0].data);
                    check_val("wd_cidx", A_colidx_input, sb[0].cidx);
                    check_val("wd_idx", idx, sb[0].idx);
                end
                if (tmon_en) check_val("wd_cycle", cyc - hs_cyc, 5);
            end
            if (write_cidx_en) begin
                check_val("sb_nonempty_wc", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    check_val("wc_data", A_data_input, sb[0].data);
                    check_val("wc_cidx", A_colidx_input, sb[0].cidx);
                    check_val("wc_idx", idx, sb[0].idx);
                    check_val("wc_nnz", row_nnz, sb[0].nnz);
                    check_val("wc_ptr", row_ptr, sb[0].ptr);
                    check_val("wc_tile_done", tile_done, sb[0].td);
                    void'(sb.pop_front());
                end
                if (tmon_en) check_val("wc_cycle", cyc - hs_cyc, 6);
            end
            if (tmon_en && (cyc == hs_cyc + 3)) check_val("busy_ready", in_ready, 1'b0);
            if (tmon_en && (cyc == hs_cyc + 7)) check_val("ready_back", in_ready, 1'b1);
        end
    end

    initial begin
        int w;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_row   = '0;
        in_last  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", in_ready, 1'b1);
        check_val("rst_wde", write_data_en, 1'b0);
        check_val("rst_wce", write_cidx_en, 1'b0);
        check_val("rst_idx", idx, 4'd0);
        check_val("rst_ptr", row_ptr, 8'd0);
        check_val("rst_nnz", row_nnz, 5'd0);
        check_val("rst_data", A_data_input, 256'd0);
        check_val("rst_cidx", A_colidx_input, 256'd0);
        check_val("rst_td", tile_done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Sparse row: col0=1, col3=5, col7=9 (closes its own tile)
        row_v = '0;
        row_v[0*16 +: 16] = 16'd1;
        row_v[3*16 +: 16] = 16'd5;
        row_v[7*16 +: 16] = 16'd9;
        send_row(row_v, 1'b1, 1);

        // All-zero row, then fully dense row with value j+1 at column j
        send_row(256'd0, 1'b0, 1);
        row_v = '0;
        for (int j = 0; j < 16; j++) row_v[j*16 +: 16] = 16'(j + 1);
        send_row(row_v, 1'b1, 1);

        // Full tile of 16 rows, two nonzeros each, last row flagged
        for (int r = 0; r < 16; r++) begin
            row_v = '0;
            row_v[$urandom_range(0, 7)*16 +: 16]  = 16'($urandom_range(1, 65535));
            row_v[$urandom_range(8, 15)*16 +: 16] = 16'($urandom_range(1, 65535));
            send_row(row_v, (r == 15), 1);
        end

        // Sign-bit-only value is nonzero; in_valid held through the busy phase
        row_v = '0;
        row_v[2*16 +: 16] = 16'h8000;
        send_row(row_v, 1'b0, 6);

        // Two random rows (idx 1, 2), then reset during SCAN of row idx 3
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 16; j++)
                row_v[j*16 +: 16] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            send_row(row_v, 1'b0, 1);
        end
        for (int j = 0; j < 16; j++) row_v[j*16 +: 16] = 16'(j + 100);
        send_row(row_v, 1'b0, 1);
        @(posedge clk); #1;
        reset   = 1'b1;
        tmon_en = 1'b0;
        sb.delete();
        m_idx   = 4'd0;
        m_ptr   = 8'd0;
        #1;
        check_val("abort_ready", in_ready, 1'b1);
        check_val("abort_wde", write_data_en, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end

        // Row after the abort restarts at idx 0 / row_ptr 0; then random traffic
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 16; j++)
                row_v[j*16 +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            send_row(row_v, (r == 5), 1);
        end

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_val("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
